mem_access_stage: RTL and testbench

Memory-access stage between the EX/MEM and MEM/WB pipeline registers. It drives a request/acknowledge data-memory bus for loads and stores. It aligns and extends load data, and generates byte enables for stores. It stalls the upstream pipeline while an access is outstanding and presents MEM/WB with either a completed result or a bubble.

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/mem_access_stage_load_align.sv | 32 +++
 rtl/mem_access_stage.sv | 156 +++++++++++++++
 tb/tb_mem_access_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and defaults for the memory-access stage
// Purpose: mem_size encodings, FSM state type and default ack timeout.
// Ports: none (package).
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// rtl/mem_access_stage_load_align.sv - load data extract and extend
// Purpose: picks the addressed byte/half/word out of a read word and extends it.
// Ports:
//   rdata    in  32  raw bus read word
//   addr     in  2   byte offset within the word
//   size     in  2   SZ_BYTE / SZ_HALF / word (reserved encoding acts as word)
//   unsigned_ld in 1 zero-extend when 1, sign-extend when 0
//   data     out 32  aligned, extended load value
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    case (size)
      SZ_BYTE: data = unsigned_ld ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = unsigned_ld ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory-access stage with req/ack data bus
// Purpose: issues loads/stores, stalls upstream while an access is pending and
// hands MEM/WB either a completed result or a bubble.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses after MEM_TIMEOUT
// wait cycles (bus_err pulse); otherwise bus_err is 0 and no counter exists.
// Ports:
//   clk, reset                      clock, async active-high reset
//   ex_valid, alu_result, store_data, rd_address, RegWrite, MemtoReg,
//   MemRead, MemWrite, mem_size, mem_unsigned        EX/MEM inputs
//   alu_data, rd, rd_address_out, RegWrite_out, MemtoReg_out  MEM/WB outputs
//   mem_stall, misalign_exc, bus_err                 pipeline status
//   dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, dmem_ack, dmem_rdata  bus
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_address,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] alu_data,
  output logic [31:0] rd,
  output logic [4:0]  rd_address_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        mem_stall,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  state_t      state_q, state_d;
  logic        mem_op, misalign, access, timeout, req, complete, fwd, out_en;
  logic [31:0] load_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout = (state_q == ST_WAIT) && (cnt_q == CW'(MEM_TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr        (alu_result[1:0]),
    .size        (mem_size),
    .unsigned_ld (mem_unsigned),
    .data        (load_data)
  );

  always_comb begin
    mem_op = ex_valid & (MemRead | MemWrite);
    case (mem_size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = alu_result[0];
      default: misalign = |alu_result[1:0];
    endcase
    misalign = misalign & mem_op;
    access   = mem_op & ~misalign;
    // In WAIT the op is held by the upstream stall; an aborted op drops req.
    req      = (state_q == ST_IDLE) ? access : ~timeout;
    complete = req & dmem_ack;
    fwd      = (ex_valid & ~mem_op) | complete;
    out_en   = ~reset;
  end

  always_comb begin
    state_d = state_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (access && !dmem_ack) begin
          state_d = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = CW'(1);
`endif
        end
      end
      default: begin
        if (dmem_ack || timeout) begin
          state_d = ST_IDLE;
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Everything is forced low during reset so a dropped WAIT releases at once.
  always_comb begin
    alu_data       = (out_en & fwd) ? alu_result : 32'h0;
    rd             = (out_en & complete & MemRead & ~MemWrite) ? load_data : 32'h0;
    rd_address_out = (out_en & fwd) ? rd_address : 5'h0;
    RegWrite_out   = out_en & fwd & RegWrite;
    MemtoReg_out   = out_en & fwd & MemtoReg;
    mem_stall      = out_en & req & ~dmem_ack;
    misalign_exc   = out_en & misalign & (state_q == ST_IDLE);
    bus_err        = out_en & timeout;
    dmem_req       = out_en & req;
    dmem_we        = out_en & req & MemWrite;
    dmem_addr      = out_en ? {alu_result[31:2], 2'b00} : 32'h0;
    case (mem_size)
      SZ_BYTE: begin
        dmem_be    = 4'b0001 << alu_result[1:0];
        dmem_wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        dmem_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{store_data[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = store_data;
      end
    endcase
    if (!out_en) begin
      dmem_be    = 4'h0;
      dmem_wdata = 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, RegWrite, MemtoReg, MemRead, MemWrite, mem_unsigned;
  logic [31:0] alu_result, store_data, dmem_rdata;
  logic [4:0]  rd_address;
  logic [1:0]  mem_size;
  logic        dmem_ack;
  logic [31:0] alu_data, rd, dmem_addr, dmem_wdata;
  logic [4:0]  rd_address_out;
  logic        RegWrite_out, MemtoReg_out, mem_stall, misalign_exc, bus_err;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] alu, rd;
    logic        chk_rd;
    logic [4:0]  rda;
    logic        rw, m2r, stall, req, mis, berr;
    logic        chk_bus;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        we;
  } exp_t;

  always #5 clk = ~clk;

  mem_access_stage #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .alu_result(alu_result),
    .store_data(store_data), .rd_address(rd_address), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .alu_data(alu_data),
    .rd(rd), .rd_address_out(rd_address_out), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .mem_stall(mem_stall),
    .misalign_exc(misalign_exc), .bus_err(bus_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bubble(input logic stall, input logic req);
    exp_t e;
    e = '{alu: 32'h0, rd: 32'h0, chk_rd: 1'b1, rda: 5'h0, rw: 1'b0, m2r: 1'b0,
          stall: stall, req: req, mis: 1'b0, berr: 1'b0, chk_bus: 1'b0,
          addr: 32'h0, wdata: 32'h0, be: 4'h0, we: 1'b0};
    return e;
  endfunction

  // Checks one cycle at the falling edge, then moves to just after the next rise.
  task automatic expect_out(input string tag, input exp_t e);
    @(negedge clk);
    chk({tag, ".alu_data"}, alu_data, e.alu);
    if (e.chk_rd) chk({tag, ".rd"}, rd, e.rd);
    chk({tag, ".rd_address_out"}, 32'(rd_address_out), 32'(e.rda));
    chk({tag, ".RegWrite_out"}, 32'(RegWrite_out), 32'(e.rw));
    chk({tag, ".MemtoReg_out"}, 32'(MemtoReg_out), 32'(e.m2r));
    chk({tag, ".mem_stall"}, 32'(mem_stall), 32'(e.stall));
    chk({tag, ".dmem_req"}, 32'(dmem_req), 32'(e.req));
    chk({tag, ".misalign_exc"}, 32'(misalign_exc), 32'(e.mis));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(e.berr));
    if (e.chk_bus) begin
      chk({tag, ".dmem_addr"}, dmem_addr, e.addr);
      chk({tag, ".dmem_wdata"}, dmem_wdata, e.wdata);
      chk({tag, ".dmem_be"}, 32'(dmem_be), 32'(e.be));
      chk({tag, ".dmem_we"}, 32'(dmem_we), 32'(e.we));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic mr, input logic mw, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rda, input logic rw, input logic m2r);
    ex_valid = ev; MemRead = mr; MemWrite = mw; mem_size = sz; mem_unsigned = uns;
    alu_result = addr; store_data = sd; rd_address = rda; RegWrite = rw; MemtoReg = m2r;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Reference: gather bytes little-endian from the word, then extend arithmetically.
  function automatic logic [31:0] load_ref(input logic [31:0] w, input int off, input int nb,
                                           input bit uns);
    longint v = 0;
    for (int i = 0; i < nb; i++) v = v | (longint'(w[8*(off+i) +: 8]) << (8*i));
    if (!uns && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
    return v[31:0];
  endfunction

  function automatic exp_t bus_ref(input exp_t e, input logic [31:0] addr, input logic [31:0] sd,
                                   input logic [1:0] sz, input logic mw);
    exp_t r = e;
    int nb = nbytes(sz);
    int off = int'(addr[1:0]);
    r.chk_bus = 1'b1;
    r.addr = {addr[31:2], 2'b00};
    r.we = mw;
    for (int k = 0; k < 4; k++) begin
      r.be[k] = (k >= off) && (k < off + nb);
      r.wdata[8*k +: 8] = sd[8*(k % nb) +: 8];
    end
    return r;
  endfunction

  initial begin
    exp_t e;
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(1, 0, 0, SZ_WORD, 0, 32'h1234, 32'h5678, 5'd5, 1, 0);

    // Reset: every output forced low
    e = bubble(0, 0); e.chk_bus = 1'b1;
    expect_out("reset", e);
    reset = 1'b0;

    // ALU op passes through in the same cycle
    e = bubble(0, 0); e.alu = 32'h1234; e.rda = 5'd5; e.rw = 1'b1;
    expect_out("alu_op", e);

    // ex_valid low yields a bubble even with MemRead set
    drive(0, 1, 0, SZ_WORD, 0, 32'h40, 32'h0, 5'd9, 1, 1);
    dmem_ack = 1'b1;
    expect_out("invalid", bubble(0, 0));
    dmem_ack = 1'b0;

    // Signed byte load at 0x103 with two wait cycles
    drive(1, 1, 0, SZ_BYTE, 0, 32'h103, 32'h0, 5'd7, 1, 1);
    dmem_rdata = 32'h80FF_0000;
    expect_out("lb_wait0", bubble(1, 1));
    expect_out("lb_wait1", bubble(1, 1));
    dmem_ack = 1'b1;
    e = bubble(0, 1); e.alu = 32'h103; e.rd = 32'hFFFF_FF80; e.rda = 5'd7; e.rw = 1; e.m2r = 1;
    expect_out("lb_done", bus_ref(e, 32'h103, 32'h0, SZ_BYTE, 1'b0));

    // Half store at 0x102, zero-wait
    drive(1, 0, 1, SZ_HALF, 0, 32'h102, 32'hAAAA_BEEF, 5'd0, 0, 0);
    e = bubble(0, 1); e.alu = 32'h102; e.chk_rd = 1'b0; e.chk_bus = 1'b1;
    e.addr = 32'h100; e.wdata = 32'hBEEF_BEEF; e.be = 4'b1100; e.we = 1'b1;
    expect_out("sh_done", e);
    dmem_ack = 1'b0;

    // Misaligned word load: one-cycle exception, no request
    drive(1, 1, 0, SZ_WORD, 0, 32'h101, 32'h0, 5'd3, 1, 1);
    e = bubble(0, 0); e.mis = 1'b1;
    expect_out("misalign", e);
    drive(1, 0, 0, SZ_WORD, 0, 32'h55, 32'h0, 5'd4, 1, 0);
    e = bubble(0, 0); e.alu = 32'h55; e.rda = 5'd4; e.rw = 1'b1;
    expect_out("after_misalign", e);

    // Reset while waiting drops request and stall at once
    drive(1, 1, 0, SZ_WORD, 0, 32'h200, 32'h0, 5'd8, 1, 1);
    expect_out("rst_wait0", bubble(1, 1));
    expect_out("rst_wait1", bubble(1, 1));
    reset = 1'b1;
    e = bubble(0, 0); e.chk_bus = 1'b1;
    expect_out("rst_mid_wait", e);
    reset = 1'b0;
    drive(0, 0, 0, SZ_WORD, 0, 32'h0, 32'h0, 5'd0, 0, 0);
    dmem_ack = 1'b1;
    expect_out("late_ack", bubble(0, 0));
    dmem_ack = 1'b0;
    drive(1, 1, 0, SZ_WORD, 1, 32'h300, 32'h0, 5'd2, 1, 1);
    dmem_rdata = 32'hCAFE_F00D;
    expect_out("post_rst_wait", bubble(1, 1));
    dmem_ack = 1'b1;
    e = bubble(0, 1); e.alu = 32'h300; e.rd = 32'hCAFE_F00D; e.rda = 5'd2; e.rw = 1; e.m2r = 1;
    expect_out("post_rst_done", e);
    dmem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // No ack: four stall cycles, then abort with bus_err
    drive(1, 1, 0, SZ_WORD, 0, 32'h400, 32'h0, 5'd6, 1, 1);
    for (int i = 0; i < 4; i++) expect_out($sformatf("to_wait%0d", i), bubble(1, 1));
    e = bubble(0, 0); e.berr = 1'b1;
    expect_out("timeout", e);
    drive(1, 0, 0, SZ_WORD, 0, 32'h77, 32'h0, 5'd1, 1, 0);
    e = bubble(0, 0); e.alu = 32'h77; e.rda = 5'd1; e.rw = 1'b1;
    expect_out("after_timeout", e);
`endif

    // Randomized loads/stores against the reference model
    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 2);
      logic [1:0] sz = 2'($urandom_range(0, 3));
      bit mis = (sz != SZ_BYTE) && ($urandom_range(0, 4) == 0);
      logic [31:0] addr = $urandom;
      logic [31:0] sd = $urandom;
      logic [31:0] rdw = $urandom;
      int waits = $urandom_range(0, 3);
      logic mr = (kind != 1);
      logic mw = (kind != 0);
      logic uns = 1'($urandom_range(0, 1));
      logic [4:0] rda = 5'($urandom_range(0, 31));
      logic rw = 1'($urandom_range(0, 1));
      logic m2r = 1'($urandom_range(0, 1));
      int nb = nbytes(sz);
      if (sz == SZ_HALF) addr[0] = mis;
      else if (sz != SZ_BYTE) addr[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
      drive(1, mr, mw, sz, uns, addr, sd, rda, rw, m2r);
      dmem_rdata = rdw;
      dmem_ack = 1'b0;
      if (mis) begin
        e = bubble(0, 0); e.mis = 1'b1;
        expect_out($sformatf("rnd%0d_mis", t), e);
      end else begin
        for (int w = 0; w < waits; w++)
          expect_out($sformatf("rnd%0d_wait%0d", t, w),
                     bus_ref(bubble(1, 1), addr, sd, sz, mw));
        dmem_ack = 1'b1;
        e = bubble(0, 1); e.alu = addr; e.rda = rda; e.rw = rw; e.m2r = m2r;
        e.chk_rd = 1'b1;
        e.rd = (mr && !mw) ? load_ref(rdw, int'(addr[1:0]), nb, uns) : 32'h0;
        if (mw) e.chk_rd = 1'b0;
        expect_out($sformatf("rnd%0d_done", t), bus_ref(e, addr, sd, sz, mw));
        dmem_ack = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
